// File: rtl/nw_pkg.sv
// Shared types for the Grid aligner front-end: nucleotide codes, loader states
// and the ASCII-to-code decode helper.
package nw_pkg;

  localparam int CWIDTH = 2;

  localparam logic [CWIDTH-1:0] NT_A = 2'b00;
  localparam logic [CWIDTH-1:0] NT_C = 2'b01;
  localparam logic [CWIDTH-1:0] NT_G = 2'b10;
  localparam logic [CWIDTH-1:0] NT_T = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_S1 = 3'd1,
    LOAD_S2 = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Returns {code, is_valid}; case-insensitive ACGT, anything else is invalid.
  function automatic logic [CWIDTH:0] decode_char(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61: return {NT_A, 1'b1};
      8'h43, 8'h63: return {NT_C, 1'b1};
      8'h47, 8'h67: return {NT_G, 1'b1};
      8'h54, 8'h74: return {NT_T, 1'b1};
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/nw_char_decode.sv
// Combinational ASCII nucleotide decoder: byte in, 2-bit code plus valid flag out.
module nw_char_decode
  import nw_pkg::*;
(
  input  logic [7:0]        data,
  output logic [CWIDTH-1:0] code,
  output logic              is_valid
);

  logic [CWIDTH:0] dec;

  always_comb begin
    dec      = decode_char(data);
    code     = dec[CWIDTH:1];
    is_valid = dec[0];
  end

endmodule

// File: rtl/nw_seq_loader.sv
// Loads two nucleotide sequences from a byte stream, runs the Grid and times it.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready is registered.
module nw_seq_loader
  import nw_pkg::*;
#(
  parameter int LENGTH   = 10,
  parameter int CNTWIDTH = 16,
  parameter int TIMEOUT  = 4*LENGTH+8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [LENGTH*CWIDTH-1:0] s1,
  output logic [LENGTH*CWIDTH-1:0] s2,
  output logic                     grid_reset,
  input  logic                     grid_valid,
  output logic                     done,
  output logic                     err,
  output logic [CNTWIDTH-1:0]      cycles,
  output state_t                   state
);

  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNTWIDTH-1:0] TIMEOUT_C = CNTWIDTH'(TIMEOUT);
  localparam logic [CNTWIDTH-1:0] CNT_MAX   = {CNTWIDTH{1'b1}};

  logic [IW-1:0]       idx;
  logic [CNTWIDTH-1:0] cnt;
  logic [CWIDTH-1:0]   code;
  logic                char_ok;
  logic                accept;
  logic                last_idx;
  int unsigned         slot;

  nw_char_decode u_decode (
    .data     (in_data),
    .code     (code),
    .is_valid (char_ok)
  );

  always_comb begin
    accept   = in_valid && in_ready;
    last_idx = (idx == IW'(LENGTH-1));
    // First character lands in the most significant slot.
    slot     = (LENGTH - 1) - int'(idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      grid_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      cycles     <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD_S1;
            in_ready   <= 1'b1;
            grid_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
          end
        end
        LOAD_S1, LOAD_S2: begin
          if (accept) begin
            if (!char_ok) begin
              err <= 1'b1;
            end else begin
              if (state == LOAD_S1) s1[slot*CWIDTH +: CWIDTH] <= code;
              else                  s2[slot*CWIDTH +: CWIDTH] <= code;
              if (last_idx) begin
                idx <= '0;
                if (state == LOAD_S1) begin
                  state <= LOAD_S2;
                end else begin
                  // Release the grid and start timing in the same edge.
                  state      <= RUN;
                  in_ready   <= 1'b0;
                  grid_reset <= 1'b0;
                  cnt        <= CNTWIDTH'(1);
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (grid_valid) begin
            state  <= DONE;
            done   <= 1'b1;
            cycles <= cnt;
          end else if (cnt >= TIMEOUT_C) begin
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
            cycles <= TIMEOUT_C;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
